trace_buffer: RTL and testbench
===============================

Name: trace_buffer

Overview:
- Synthesizable on-chip trace capture for the single-cycle MIPS core (sccomp_dataflow); records per-cycle commit state (pc, inst, register-file write) into a circular buffer.
- PC-match trigger, configurable post-trigger window, two capture modes.
- Oldest-first readout over a valid/ready stream, so traces can be pulled on hardware instead of only by simulation file dumps.

Parameters:
- DEPTH, 64, entries in buffer; power of two, >= 4.
- POST_TRIG, 16, qualified samples written after the trigger sample; 0 <= POST_TRIG < DEPTH.
- CYC_W, 32, width of free-running cycle stamp.
- (derived) AW = log2(DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- pc  in  32  current PC.
- inst  in  32  current instruction.
- rf_wena  in  1  register-file write enable.
- rf_waddr  in  5  register-file write address.
- rf_wdata  in  32  register-file write data.
- mode  in  1  0 = capture every cycle; 1 = capture only rf_wena && rf_waddr != 0.
- arm  in  1  start capture (honoured in IDLE only).
- abort  in  1  return to IDLE, discard buffer.
- trig_en  in  1  enable PC-match trigger.
- trig_pc  in  32  trigger PC.
- trig_force  in  1  immediate trigger.
- dump_start  in  1  begin readout (honoured in DONE only).
- out_valid  out  1  readout entry valid.
- out_ready  in  1  consumer accepts entry.
- out_cyc  out  CYC_W  entry cycle stamp.
- out_pc  out  32  entry PC.
- out_inst  out  32  entry instruction.
- out_wena  out  1  entry rf write enable.
- out_waddr  out  5  entry rf write address.
- out_wdata  out  32  entry rf write data.
- state  out  3  IDLE=0, ARMED=1, POST=2, DONE=3, DUMP=4.
- triggered  out  1  trigger has occurred in the current capture.
- fill  out  AW+1  valid entries, saturates at DEPTH.

Behaviour:
- Reset: state IDLE; wr_ptr, rd_ptr, fill, post_cnt, cycle stamp = 0; out_valid = 0; triggered = 0; all out_* data = 0.
- Cycle stamp increments every clk after reset and wraps modulo 2^CYC_W. Each entry records the stamp of its sample cycle.
- qual = (mode == 0) | (rf_wena & rf_waddr != 0).
- IDLE:
  - arm -> ARMED; wr_ptr, fill, triggered cleared.
  - dump_start ignored.
- ARMED:
  - Each qual cycle writes an entry at wr_ptr; wr_ptr wraps modulo DEPTH; fill saturates at DEPTH (oldest overwritten).
  - Trigger = trig_force | (trig_en & pc == trig_pc & qual).
  - On trigger: that cycle's sample is written and triggered = 1. If POST_TRIG == 0 -> DONE, else -> POST with post_cnt = 0.
- POST:
  - qual cycles write entries and increment post_cnt.
  - The write that brings post_cnt to POST_TRIG moves to DONE on the next edge.
  - Further trigger conditions are ignored.
- DONE:
  - Buffer frozen; no writes.
  - dump_start -> DUMP; rd_ptr = (wr_ptr - fill) mod DEPTH; remaining = fill.
- DUMP:
  - Buffer read is registered. out_valid first rises 1 cycle after entering DUMP.
  - out_* data stays stable while out_valid & !out_ready.
  - On out_valid & out_ready: next entry is presented with no bubble when available.
  - After the last handshake: out_valid = 0 and state -> IDLE in the same edge; fill cleared.
  - fill == 0 on dump_start: DUMP lasts 1 cycle, no out_valid, then IDLE.
- abort: any state -> IDLE next edge; fill, triggered, out_valid cleared. Abort beats trigger, arm and dump_start in the same cycle.
- rst mid-operation: identical to reset values, regardless of state.
- No write occurs in IDLE, DONE or DUMP; the buffer is single-port-safe (write and read never overlap).

Decomposition:
- Package trace_pkg:
  - state encoding constants.
  - entry width constant: CYC_W + 102.
  - Entry field offset constants.
- Sub-module trace_ram: DEPTH x entry-width simple dual-port RAM with synchronous write and registered read, inferable as BRAM.
- FSM, pointers and output skid logic live in trace_buffer.

Test Plan:
1. Reset with DEPTH=8, POST_TRIG=3 -> state=0, fill=0, out_valid=0, triggered=0.
2. Mode 0, arm with pc=0x00, pc +4 per cycle, trig_en=1, trig_pc=0x40 -> DONE after pc 0x4C is written; fill=8; dump yields 8 entries, pc 0x30..0x4C in order, consecutive cycle stamps.
3. Arm, then trig_force on the 2nd sample -> fill=5; dump yields 5 entries, oldest first, the 2nd carrying triggered sample's pc.
4. Mode 1 with writes to r8 (data 0x1234), r0 (data 0xFFFF), r9 (data 0x5678), then trigger -> r0 write absent; entries show waddr 8 then 9 with matching data.
5. Mid-dump, out_ready=0 for 3 cycles -> out_* held constant; total entries = fill with no duplicate or loss; state returns to 0 after last handshake.
6. abort asserted in POST together with trig_force -> next cycle state=0, fill=0, triggered=0; subsequent dump_start gives no out_valid.

Source files
------------

// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared state encoding and trace entry layout for trace_buffer
package trace_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_POST  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DUMP  = 3'd4
    } state_e;

    // Entry layout, LSB first: wdata, waddr, wena, inst, pc, then the cycle stamp on top.
    localparam int ENT_WDATA_LSB = 0;
    localparam int ENT_WADDR_LSB = 32;
    localparam int ENT_WENA_BIT  = 37;
    localparam int ENT_INST_LSB  = 38;
    localparam int ENT_PC_LSB    = 70;
    localparam int ENT_CYC_LSB   = 102;
    localparam int ENT_BASE_W    = 102;

    function automatic int entry_w(input int cyc_w);
        return cyc_w + ENT_BASE_W;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// rtl/trace_ram.sv - simple dual-port trace storage, synchronous write, registered read
module trace_ram #(
    parameter int DEPTH = 64,
    parameter int W     = 134
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    // Output register holds its value while re_i is low; the readout stall relies on that.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/trace_buffer.sv
// rtl/trace_buffer.sv - triggered circular commit-trace capture with oldest-first stream readout
module trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int POST_TRIG = 16,
    parameter int CYC_W     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              pc,
    input  logic [31:0]              inst,
    input  logic                     rf_wena,
    input  logic [4:0]               rf_waddr,
    input  logic [31:0]              rf_wdata,
    input  logic                     mode,
    input  logic                     arm,
    input  logic                     abort,
    input  logic                     trig_en,
    input  logic [31:0]              trig_pc,
    input  logic                     trig_force,
    input  logic                     dump_start,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CYC_W-1:0]         out_cyc,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_inst,
    output logic                     out_wena,
    output logic [4:0]               out_waddr,
    output logic [31:0]              out_wdata,
    output logic [2:0]               state,
    output logic                     triggered,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int             AW        = $clog2(DEPTH);
    localparam int             EW        = entry_w(CYC_W);
    localparam logic [AW:0]    FILL_MAX  = (AW+1)'(DEPTH);
    localparam logic [AW:0]    POST_LAST = (AW+1)'(POST_TRIG);
    localparam logic [AW:0]    ONE_W     = (AW+1)'(1);
    localparam logic [AW-1:0]  ONE_P     = AW'(1);

    state_e            state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       fill_q, fill_d;
    logic [AW:0]       post_cnt_q, post_cnt_d;
    logic [AW:0]       left_q, left_d;
    logic              trig_q, trig_d;
    logic              out_valid_q, out_valid_d;
    logic [CYC_W-1:0]  cyc_q;

    logic              qual;
    logic              trig_hit;
    logic              ram_we;
    logic              ram_re;
    logic [EW-1:0]     ram_wdata;
    logic [EW-1:0]     ram_rdata;

    assign qual      = !mode || (rf_wena && (rf_waddr != 5'd0));
    assign trig_hit  = trig_force || (trig_en && (pc == trig_pc) && qual);
    assign ram_wdata = {cyc_q, pc, inst, rf_wena, rf_waddr, rf_wdata};

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_d      = fill_q;
        post_cnt_d  = post_cnt_q;
        left_d      = left_q;
        trig_d      = trig_q;
        out_valid_d = out_valid_q;
        ram_we      = 1'b0;
        ram_re      = 1'b0;

        if (abort) begin
            state_d     = ST_IDLE;
            fill_d      = '0;
            trig_d      = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arm) begin
                        state_d  = ST_ARMED;
                        wr_ptr_d = '0;
                        fill_d   = '0;
                        trig_d   = 1'b0;
                    end
                end
                ST_ARMED: begin
                    // A forced trigger records its sample even when the cycle is not qualified.
                    if (qual || trig_hit) begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_P;
                        fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + ONE_W;
                    end
                    if (trig_hit) begin
                        trig_d     = 1'b1;
                        post_cnt_d = '0;
                        state_d    = (POST_TRIG == 0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (qual) begin
                        ram_we     = 1'b1;
                        wr_ptr_d   = wr_ptr_q + ONE_P;
                        fill_d     = (fill_q == FILL_MAX) ? fill_q : fill_q + ONE_W;
                        post_cnt_d = post_cnt_q + ONE_W;
                        if (post_cnt_q + ONE_W == POST_LAST) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (dump_start) begin
                        state_d  = ST_DUMP;
                        rd_ptr_d = wr_ptr_q - fill_q[AW-1:0];
                        left_d   = fill_q;
                    end
                end
                ST_DUMP: begin
                    // Fetch only when the output slot is empty or being drained this cycle.
                    if (!out_valid_q || out_ready) begin
                        if (left_q != '0) begin
                            ram_re      = 1'b1;
                            rd_ptr_d    = rd_ptr_q + ONE_P;
                            left_d      = left_q - ONE_W;
                            out_valid_d = 1'b1;
                        end else begin
                            out_valid_d = 1'b0;
                            state_d     = ST_IDLE;
                            fill_d      = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            post_cnt_q  <= '0;
            left_q      <= '0;
            trig_q      <= 1'b0;
            out_valid_q <= 1'b0;
            cyc_q       <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_q      <= fill_d;
            post_cnt_q  <= post_cnt_d;
            left_q      <= left_d;
            trig_q      <= trig_d;
            out_valid_q <= out_valid_d;
            cyc_q       <= cyc_q + CYC_W'(1);
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign out_valid = out_valid_q;
    assign out_cyc   = ram_rdata[ENT_CYC_LSB +: CYC_W];
    assign out_pc    = ram_rdata[ENT_PC_LSB +: 32];
    assign out_inst  = ram_rdata[ENT_INST_LSB +: 32];
    assign out_wena  = ram_rdata[ENT_WENA_BIT];
    assign out_waddr = ram_rdata[ENT_WADDR_LSB +: 5];
    assign out_wdata = ram_rdata[ENT_WDATA_LSB +: 32];
    assign state     = state_q;
    assign triggered = trig_q;
    assign fill      = fill_q;

endmodule

// File: tb/tb_trace_buffer.sv
// tb/tb_trace_buffer.sv - directed self-checking bench for trace_buffer
module tb_trace_buffer;

    localparam int DEPTH     = 8;
    localparam int POST_TRIG = 3;
    localparam int CYC_W     = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc, inst, rf_wdata, trig_pc;
    logic        rf_wena, mode, arm, abort, trig_en, trig_force, dump_start, out_ready;
    logic [4:0]  rf_waddr;
    logic        out_valid, out_wena, triggered;
    logic [31:0] out_cyc, out_pc, out_inst, out_wdata;
    logic [4:0]  out_waddr;
    logic [2:0]  state;
    logic [3:0]  fill;

    always #5 clk = ~clk;

    trace_buffer #(.DEPTH(DEPTH), .POST_TRIG(POST_TRIG), .CYC_W(CYC_W)) dut (
        .clk(clk), .rst(rst), .pc(pc), .inst(inst), .rf_wena(rf_wena), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .mode(mode), .arm(arm), .abort(abort), .trig_en(trig_en),
        .trig_pc(trig_pc), .trig_force(trig_force), .dump_start(dump_start),
        .out_valid(out_valid), .out_ready(out_ready), .out_cyc(out_cyc), .out_pc(out_pc),
        .out_inst(out_inst), .out_wena(out_wena), .out_waddr(out_waddr), .out_wdata(out_wdata),
        .state(state), .triggered(triggered), .fill(fill)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] tb_cyc;
    always @(posedge clk) begin
        if (rst) tb_cyc <= 32'd0;
        else     tb_cyc <= tb_cyc + 32'd1;
    end

    logic [31:0] got_pc    [16];
    logic [31:0] got_cyc   [16];
    logic [31:0] got_wdata [16];
    logic [4:0]  got_waddr [16];
    logic        got_wena  [16];
    int          n_got;

    task automatic idle_inputs();
        pc = 32'd0; inst = 32'd0; rf_wena = 1'b0; rf_waddr = 5'd0; rf_wdata = 32'd0;
        mode = 1'b0; arm = 1'b0; abort = 1'b0; trig_en = 1'b0; trig_pc = 32'd0;
        trig_force = 1'b0; dump_start = 1'b0; out_ready = 1'b1;
    endtask

    task automatic do_dump(input int stall_at, input int stall_len);
        int          stalls;
        bit          done;
        logic [31:0] snap_pc, snap_cyc;
        n_got = 0; stalls = 0; done = 0; snap_pc = 0; snap_cyc = 0;
        dump_start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        checks++;
        if (state !== 3'd4 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL dump_first_cycle: state=%0d out_valid=%0b, want 4/0", state, out_valid);
        end
        for (int c = 0; c < 100 && !done; c++) begin
            if (out_valid && n_got == stall_at && stalls < stall_len) begin
                if (stalls == 0) begin
                    snap_pc = out_pc; snap_cyc = out_cyc;
                end else begin
                    checks++;
                    if (out_valid !== 1'b1 || out_pc !== snap_pc || out_cyc !== snap_cyc) begin
                        errors++;
                        $display("FAIL stall_hold: valid=%0b pc=%h cyc=%h, want 1/%h/%h",
                                 out_valid, out_pc, out_cyc, snap_pc, snap_cyc);
                    end
                end
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
                if (out_valid && n_got < 16) begin
                    got_pc[n_got] = out_pc; got_cyc[n_got] = out_cyc;
                    got_wdata[n_got] = out_wdata; got_waddr[n_got] = out_waddr;
                    got_wena[n_got] = out_wena;
                    n_got++;
                end else if (!out_valid && state == 3'd0) begin
                    done = 1;
                end
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL dump_timeout: state=%0d after budget, want 0", state);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (state !== 3'd0 || fill !== 4'd0 || out_valid !== 1'b0 || triggered !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: state=%0d fill=%0d valid=%0b trig=%0b, want 0/0/0/0",
                     state, fill, out_valid, triggered);
        end
        checks++;
        if (out_pc !== 32'd0 || out_cyc !== 32'd0 || out_wdata !== 32'd0 || out_waddr !== 5'd0) begin
            errors++;
            $display("FAIL reset_data: pc=%h cyc=%h wdata=%h waddr=%0d, want 0", out_pc, out_cyc,
                     out_wdata, out_waddr);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_pc_trigger();
        bit          reached;
        int          last_i;
        logic [31:0] t0;
        reached = 0; last_i = -1; t0 = 0;
        idle_inputs();
        trig_en = 1'b1; trig_pc = 32'h40; pc = 32'hDEAD_0000; arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        checks++;
        if (state !== 3'd1) begin
            errors++; $display("FAIL arm_state: state=%0d, want 1", state);
        end
        for (int i = 0; i < 40 && !reached; i++) begin
            pc = 32'(i * 4);
            if (i == 12) t0 = tb_cyc;
            @(negedge clk);
            if (state == 3'd3) begin reached = 1; last_i = i; end
        end
        checks++;
        if (last_i != 19) begin
            errors++; $display("FAIL pc_trig_done: done after sample %0d, want 19", last_i);
        end
        checks++;
        if (fill !== 4'd8 || triggered !== 1'b1) begin
            errors++; $display("FAIL pc_trig_fill: fill=%0d trig=%0b, want 8/1", fill, triggered);
        end
        trig_en = 1'b0;
        do_dump(-1, 0);
        checks++;
        if (n_got != 8) begin
            errors++; $display("FAIL pc_trig_count: got %0d entries, want 8", n_got);
        end
        for (int k = 0; k < 8 && k < n_got; k++) begin
            checks++;
            if (got_pc[k] !== 32'(32'h30 + 4 * k) || got_cyc[k] !== t0 + 32'(k)) begin
                errors++;
                $display("FAIL pc_trig_entry%0d: pc=%h cyc=%h, want %h/%h", k, got_pc[k], got_cyc[k],
                         32'(32'h30 + 4 * k), t0 + 32'(k));
            end
        end
    endtask

    task automatic test_force_trigger();
        idle_inputs();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0; pc = 32'h100;
        @(negedge clk);
        pc = 32'h104; trig_force = 1'b1;
        @(negedge clk);
        trig_force = 1'b0;
        for (int i = 0; i < 10 && state != 3'd3; i++) begin
            pc = 32'(32'h108 + 4 * i);
            @(negedge clk);
        end
        checks++;
        if (state !== 3'd3 || fill !== 4'd5) begin
            errors++; $display("FAIL force_fill: state=%0d fill=%0d, want 3/5", state, fill);
        end
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        checks++;
        if (state !== 3'd3) begin
            errors++; $display("FAIL done_ignores_arm: state=%0d, want 3", state);
        end
        do_dump(-1, 0);
        checks++;
        if (n_got != 5) begin
            errors++; $display("FAIL force_count: got %0d entries, want 5", n_got);
        end
        for (int k = 0; k < 5 && k < n_got; k++) begin
            checks++;
            if (got_pc[k] !== 32'(32'h100 + 4 * k)) begin
                errors++;
                $display("FAIL force_entry%0d: pc=%h, want %h", k, got_pc[k], 32'(32'h100 + 4 * k));
            end
        end
    endtask

    task automatic test_mode1();
        logic        t_wena  [10];
        logic [4:0]  t_addr  [10];
        logic [31:0] t_data  [10];
        logic [4:0]  e_addr  [6];
        logic [31:0] e_data  [6];
        t_wena = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        t_addr = '{5'd7, 5'd8, 5'd0, 5'd5, 5'd9, 5'd10, 5'd11, 5'd6, 5'd12, 5'd13};
        t_data = '{32'h7777, 32'h1234, 32'hFFFF, 32'h5555, 32'h5678,
                   32'hA, 32'hB, 32'h6666, 32'hC, 32'hD};
        e_addr = '{5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13};
        e_data = '{32'h1234, 32'h5678, 32'hA, 32'hB, 32'hC, 32'hD};
        idle_inputs();
        mode = 1'b1; arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pc = 32'(32'h200 + 4 * i);
            rf_wena = t_wena[i]; rf_waddr = t_addr[i]; rf_wdata = t_data[i];
            trig_force = (i == 5);
            @(negedge clk);
            if (i == 8) begin
                checks++;
                if (state !== 3'd2) begin
                    errors++; $display("FAIL mode1_post_gap: state=%0d, want 2", state);
                end
            end
        end
        rf_wena = 1'b0; trig_force = 1'b0;
        checks++;
        if (state !== 3'd3 || fill !== 4'd6) begin
            errors++; $display("FAIL mode1_fill: state=%0d fill=%0d, want 3/6", state, fill);
        end
        do_dump(-1, 0);
        checks++;
        if (n_got != 6) begin
            errors++; $display("FAIL mode1_count: got %0d entries, want 6", n_got);
        end
        for (int k = 0; k < 6 && k < n_got; k++) begin
            checks++;
            if (got_waddr[k] !== e_addr[k] || got_wdata[k] !== e_data[k] || got_wena[k] !== 1'b1) begin
                errors++;
                $display("FAIL mode1_entry%0d: waddr=%0d wdata=%h wena=%0b, want %0d/%h/1",
                         k, got_waddr[k], got_wdata[k], got_wena[k], e_addr[k], e_data[k]);
            end
        end
    endtask

    task automatic test_back_to_back_stall();
        idle_inputs();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pc = 32'(32'h300 + 4 * i);
            trig_force = (i == 0);
            @(negedge clk);
        end
        trig_force = 1'b0;
        checks++;
        if (state !== 3'd3 || fill !== 4'd4) begin
            errors++; $display("FAIL stall_setup: state=%0d fill=%0d, want 3/4", state, fill);
        end
        do_dump(1, 3);
        checks++;
        if (n_got != 4) begin
            errors++; $display("FAIL stall_count: got %0d entries, want 4", n_got);
        end
        for (int k = 0; k < 4 && k < n_got; k++) begin
            checks++;
            if (got_pc[k] !== 32'(32'h300 + 4 * k) || got_cyc[k] !== got_cyc[0] + 32'(k)) begin
                errors++;
                $display("FAIL stall_entry%0d: pc=%h cyc=%h, want %h/%h", k, got_pc[k], got_cyc[k],
                         32'(32'h300 + 4 * k), got_cyc[0] + 32'(k));
            end
        end
        checks++;
        if (state !== 3'd0 || fill !== 4'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_end: state=%0d fill=%0d valid=%0b, want 0/0/0", state, fill, out_valid);
        end
    endtask

    task automatic test_abort();
        int vseen;
        vseen = 0;
        idle_inputs();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0; pc = 32'h400; trig_force = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 3'd2 || triggered !== 1'b1) begin
            errors++; $display("FAIL abort_pre: state=%0d trig=%0b, want 2/1", state, triggered);
        end
        abort = 1'b1; trig_force = 1'b1; pc = 32'h404;
        @(negedge clk);
        abort = 1'b0; trig_force = 1'b0;
        checks++;
        if (state !== 3'd0 || fill !== 4'd0 || triggered !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_post: state=%0d fill=%0d trig=%0b valid=%0b, want 0/0/0/0",
                     state, fill, triggered, out_valid);
        end
        dump_start = 1'b1;
        @(negedge clk);
        dump_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_valid !== 1'b0 || state !== 3'd0) vseen++;
            @(negedge clk);
        end
        checks++;
        if (vseen != 0) begin
            errors++; $display("FAIL abort_no_dump: %0d cycles left IDLE/valid, want 0", vseen);
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        repeat (3) @(negedge clk);
        trig_force = 1'b1;
        @(negedge clk);
        trig_force = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 3'd0 || fill !== 4'd0 || triggered !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: state=%0d fill=%0d trig=%0b valid=%0b, want 0/0/0/0",
                     state, fill, triggered, out_valid);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_pc_trigger();
        test_force_trigger();
        test_mode1();
        test_back_to_back_stall();
        test_abort();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
